// File: rtl/mips_pkg.sv
// Shared pipeline constants and stage names for the forwarding scoreboard.
package mips_pkg;
  localparam int unsigned DW_DEF  = 32;
  localparam int unsigned AW_DEF  = 5;
  localparam int unsigned NST_DEF = 3;
  localparam int unsigned NRD_DEF = 2;
  localparam int unsigned TW_DEF  = 2;

  // Tracked stage index: 0 is the youngest stage after D.
  typedef enum logic [1:0] {
    ST_E = 2'd0,
    ST_M = 2'd1,
    ST_W = 2'd2
  } stage_e;
endpackage

// File: rtl/fwd_scoreboard_if.sv
// Issue, read-port and forwarding signals between D stage and the scoreboard.
interface fwd_scoreboard_if
  import mips_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned AW  = AW_DEF,
  parameter int unsigned NST = NST_DEF,
  parameter int unsigned NRD = NRD_DEF,
  parameter int unsigned TW  = TW_DEF
);
  logic               freeze;
  logic               flush;
  logic               iss_valid;
  logic [AW-1:0]      iss_addr;
  logic [TW-1:0]      iss_tnew;
  logic [NST*DW-1:0]  st_data;
  logic [NRD*AW-1:0]  rd_addr;
  logic [NRD*TW-1:0]  rd_tuse;
  logic [NRD*DW-1:0]  rf_data;
  logic [NRD*DW-1:0]  fwd_data;
  logic               stall;

  modport master (
    output freeze, flush, iss_valid, iss_addr, iss_tnew,
    output st_data, rd_addr, rd_tuse, rf_data,
    input  fwd_data, stall
  );

  modport slave (
    input  freeze, flush, iss_valid, iss_addr, iss_tnew,
    input  st_data, rd_addr, rd_tuse, rf_data,
    output fwd_data, stall
  );
endinterface

// File: rtl/fwd_scoreboard_fwd_select.sv
// Per-read-port priority match: youngest matching stage decides both the
// forwarded operand and whether this port needs a stall.
module fwd_select
  import mips_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned AW  = AW_DEF,
  parameter int unsigned NST = NST_DEF,
  parameter int unsigned TW  = TW_DEF
) (
  input  logic [NST-1:0]         v,
  input  logic [NST-1:0][AW-1:0] a,
  input  logic [NST-1:0][TW-1:0] t,
  input  logic [NST*DW-1:0]      st_data,
  input  logic [AW-1:0]          rd_addr,
  input  logic [TW-1:0]          rd_tuse,
  input  logic [DW-1:0]          rf_data,
  output logic [DW-1:0]          fwd_data,
  output logic                   stall
);
  logic hit;

  always_comb begin
    fwd_data = rf_data;
    stall    = 1'b0;
    hit      = 1'b0;
    // Once a younger stage matches, older stages are ignored even if ready.
    for (int unsigned k = 0; k < NST; k++) begin
      if (!hit && v[k] && (a[k] == rd_addr) && (rd_addr != '0)) begin
        hit = 1'b1;
        if (t[k] == '0) fwd_data = st_data[k*DW +: DW];
        stall = (t[k] > rd_tuse);
      end
    end
  end
endmodule

// File: rtl/fwd_scoreboard.sv
// Hazard scoreboard: tracks destination/readiness per stage after D and
// resolves operand forwarding and the D-stage stall.
module fwd_scoreboard
  import mips_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned AW  = AW_DEF,
  parameter int unsigned NST = NST_DEF,
  parameter int unsigned NRD = NRD_DEF,
  parameter int unsigned TW  = TW_DEF
) (
  input logic            clk,
  input logic            reset,
  fwd_scoreboard_if.slave bus
);
  logic [NST-1:0]         v;
  logic [NST-1:0][AW-1:0] a;
  logic [NST-1:0][TW-1:0] t;
  logic [NRD-1:0]         stall_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      a <= '0;
      t <= '0;
    end else if (!bus.freeze) begin
      for (int unsigned k = 1; k < NST; k++) begin
        v[k] <= v[k-1];
        a[k] <= a[k-1];
        t[k] <= (t[k-1] != '0) ? t[k-1] - TW'(1) : '0;
      end
      // Writes to $0 are never tracked so they cannot create a hazard.
      v[0] <= bus.iss_valid && (bus.iss_addr != '0) && !bus.stall && !bus.flush;
      a[0] <= bus.iss_addr;
      t[0] <= bus.iss_tnew;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    fwd_select #(
      .DW  (DW),
      .AW  (AW),
      .NST (NST),
      .TW  (TW)
    ) u_sel (
      .v        (v),
      .a        (a),
      .t        (t),
      .st_data  (bus.st_data),
      .rd_addr  (bus.rd_addr[p*AW +: AW]),
      .rd_tuse  (bus.rd_tuse[p*TW +: TW]),
      .rf_data  (bus.rf_data[p*DW +: DW]),
      .fwd_data (bus.fwd_data[p*DW +: DW]),
      .stall    (stall_p[p])
    );
  end

  assign bus.stall = |stall_p;
endmodule
